// File: rtl/apb_regbus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbus_bridge_if
// Purpose  : APB3/APB4 slave bus plus regfile strobe bus for apb_regbus_bridge.
//            The pstrb signal exists only when APB_PSTRB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_regbus_bridge_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   // APB side
   logic [ADDR_WIDTH-1:0]   paddr;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_PSTRB_EN
   logic [DATA_WIDTH/8-1:0] pstrb;
`endif
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   // Regfile side
   logic                    reg_wr_en;
   logic [ADDR_WIDTH-1:0]   reg_wr_addr;
   logic [DATA_WIDTH-1:0]   reg_wr_data;
   logic [DATA_WIDTH/8-1:0] reg_wr_be;
   logic                    reg_rd_en;
   logic [ADDR_WIDTH-1:0]   reg_rd_addr;
   logic [DATA_WIDTH-1:0]   reg_rd_data;
   logic                    reg_rd_valid;

   // Environment view: APB master plus the regfile
   modport master (
`ifdef APB_PSTRB_EN
      output pstrb,
`endif
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr,
      input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_be,
      input  reg_rd_en, reg_rd_addr,
      output reg_rd_data, reg_rd_valid
   );

   // Bridge view
   modport slave (
`ifdef APB_PSTRB_EN
      input  pstrb,
`endif
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr,
      output reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_be,
      output reg_rd_en, reg_rd_addr,
      input  reg_rd_data, reg_rd_valid
   );
endinterface
`default_nettype wire

// File: rtl/apb_regbus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbus_bridge
// Purpose  : APB slave to regfile strobe bridge. Each APB access becomes a
//            one-cycle reg_wr_en / reg_rd_en strobe; range, alignment and read
//            timeout errors are returned on pslverr.
//            Optional macro APB_PSTRB_EN: pstrb drives reg_wr_be, otherwise
//            every write uses all byte lanes.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regbus_bridge #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_LIMIT     = 'h10,
   parameter int TIMEOUT_CYCLES = 16
) (
   input wire logic           clk,
   input wire logic           rst,
   apb_regbus_bridge_if.slave bus
);
   localparam int C_BE_WIDTH  = DATA_WIDTH / 8;
   localparam int C_LSB       = $clog2(C_BE_WIDTH);
   localparam int C_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0]  C_ALIGN_MASK = ADDR_WIDTH'((1 << C_LSB) - 1);
   localparam logic [ADDR_WIDTH:0]    C_LIMIT      = (ADDR_WIDTH + 1)'(ADDR_LIMIT);
   localparam logic [C_CNT_WIDTH-1:0] C_TO_LAST    = C_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_WAIT = 3'd2,
      RESP    = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    w_access;
   logic                    w_illegal;
   logic [C_BE_WIDTH-1:0]   w_be_in;
   logic                    w_pready_next;
   logic                    w_pslverr_next;
   logic                    w_wr_en_next;
   logic                    w_rd_en_next;

   logic [C_CNT_WIDTH-1:0]  r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [C_BE_WIDTH-1:0]   r_wr_be;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic                    r_pready;
   logic                    r_pslverr;
   logic                    r_wr_en;
   logic                    r_rd_en;

   assign w_access  = bus.psel && bus.penable;
   assign w_illegal = ({1'b0, bus.paddr} >= C_LIMIT) ||
                      ((bus.paddr & C_ALIGN_MASK) != '0);

`ifdef APB_PSTRB_EN
   assign w_be_in = bus.pstrb;
`else
   assign w_be_in = '1;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and next values of the registered bus outputs
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               if (w_illegal) begin
                  w_state_next = ERR;
               end else if (bus.pwrite) begin
                  w_state_next = WR;
               end else begin
                  w_state_next = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // Master abandoning the transfer takes priority; valid beats timeout
            if (!bus.psel) begin
               w_state_next = IDLE;
            end else if (bus.reg_rd_valid) begin
               w_state_next = RESP;
            end else if (r_cnt == C_TO_LAST) begin
               w_state_next = ERR;
            end
         end
         WR, RESP, ERR: w_state_next = IDLE;
         default:       w_state_next = IDLE;
      endcase

      w_pready_next  = (w_state_next == WR) || (w_state_next == RESP) || (w_state_next == ERR);
      w_pslverr_next = (w_state_next == ERR);
      w_wr_en_next   = (w_state_next == WR);
      // Read strobe only on entry, so it never repeats while waiting
      w_rd_en_next   = (w_state_next == RD_WAIT) && (r_state != RD_WAIT);
   end

   // Address/data capture, timeout counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wr_be   <= '0;
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
      end else begin
         if ((r_state == IDLE) && w_access) begin
            r_addr  <= bus.paddr;
            r_wdata <= bus.pwdata;
         end
         // WR is only entered from IDLE, so the live strobes are the ones to latch
         r_wr_be   <= w_wr_en_next ? w_be_in : '0;
         r_cnt     <= (r_state == RD_WAIT) ? r_cnt + C_CNT_WIDTH'(1) : '0;
         if ((r_state == RD_WAIT) && (w_state_next == RESP)) begin
            r_prdata <= bus.reg_rd_data;
         end else if (w_state_next == ERR) begin
            r_prdata <= '0;
         end
         r_pready  <= w_pready_next;
         r_pslverr <= w_pslverr_next;
         r_wr_en   <= w_wr_en_next;
         r_rd_en   <= w_rd_en_next;
      end
   end

   assign bus.prdata      = r_prdata;
   assign bus.pready      = r_pready;
   assign bus.pslverr     = r_pslverr;
   assign bus.reg_wr_en   = r_wr_en;
   assign bus.reg_wr_addr = r_addr;
   assign bus.reg_wr_data = r_wdata;
   assign bus.reg_wr_be   = r_wr_be;
   assign bus.reg_rd_en   = r_rd_en;
   assign bus.reg_rd_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_apb_regbus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_regbus_bridge
// Purpose  : Self-checking bench for apb_regbus_bridge: directed cases then
//            random APB traffic against a transaction-level model.
//            Works with and without APB_PSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regbus_bridge;
   localparam int AW       = 8;
   localparam int DW       = 32;
   localparam int LIMIT    = 'h10;
   localparam int TIMEOUT  = 16;
   localparam int MAX_WAIT = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_regbus_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_regbus_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .ADDR_LIMIT     (LIMIT),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] regfile   [4];   // regfile emulated by the environment
   logic [31:0] model_mem [4];   // expected regfile contents
   logic [31:0] model_prdata;    // expected held prdata

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Regfile: commits writes on the clock edge with byte enables
   always @(posedge clk) begin
      if (bus.reg_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.reg_wr_be[b]) regfile[bus.reg_wr_addr[3:2]][8*b +: 8] = bus.reg_wr_data[8*b +: 8];
         end
      end
   end

   // Cycle-wise invariants
   logic prev_pready = 1'b0;
   always @(negedge clk) begin
      check_eq("wr_rd_exclusive", 64'(bus.reg_wr_en && bus.reg_rd_en), 64'(0));
      check_eq("pready_single",   64'(prev_pready && bus.pready), 64'(0));
      check_eq("be_idle_zero",    64'(bus.reg_wr_en ? 4'h0 : bus.reg_wr_be), 64'(0));
      prev_pready = bus.pready;
   end

   // One APB transfer; the regfile answers a read 'dly' cycles after the strobe
   task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int dly);
      logic        legal;
      logic [3:0]  exp_be;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          n_wr, n_rd, lat, wr_k, rd_k;
      logic        got_err;
      logic [31:0] got_rd, wr_data;
      logic [AW-1:0] wr_addr, rd_addr;
      logic [3:0]  wr_be;
      logic [1:0]  idx;

      legal = (32'(addr) < LIMIT) && (addr[1:0] == 2'b00);
      idx   = addr[3:2];
`ifdef APB_PSTRB_EN
      exp_be = strb;
`else
      exp_be = 4'hF;
`endif
      if (!legal) begin
         exp_lat = 1;           exp_err = 1'b1; exp_rd = 32'h0;
      end else if (wr) begin
         exp_lat = 1;           exp_err = 1'b0; exp_rd = model_prdata;
      end else if (dly < TIMEOUT) begin
         exp_lat = dly + 2;     exp_err = 1'b0; exp_rd = model_mem[idx];
      end else begin
         exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_rd = 32'h0;
      end

      n_wr = 0; n_rd = 0; lat = -1; wr_k = 0; rd_k = 0;
      got_err = 1'b0; got_rd = 32'h0; wr_data = 32'h0; wr_addr = '0; rd_addr = '0; wr_be = 4'h0;

      @(negedge clk);
      check_eq("prdata_hold", 64'(bus.prdata), 64'(model_prdata));
      bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wdata;
`ifdef APB_PSTRB_EN
      bus.pstrb = strb;
`endif
      bus.psel = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      for (int k = 1; k <= MAX_WAIT && lat < 0; k++) begin
         @(negedge clk);
         if (bus.reg_wr_en) begin
            n_wr++; wr_k = k; wr_addr = bus.reg_wr_addr; wr_data = bus.reg_wr_data; wr_be = bus.reg_wr_be;
         end
         if (bus.reg_rd_en) begin
            n_rd++; rd_k = k; rd_addr = bus.reg_rd_addr;
         end
         if (bus.pready) begin
            lat = k; got_err = bus.pslverr; got_rd = bus.prdata;
         end
         if (lat < 0 && n_rd > 0 && k == rd_k + dly) begin
            bus.reg_rd_valid = 1'b1; bus.reg_rd_data = regfile[rd_addr[3:2]];
         end else begin
            bus.reg_rd_valid = 1'b0; bus.reg_rd_data = $urandom;
         end
      end
      bus.psel = 1'b0; bus.penable = 1'b0; bus.reg_rd_valid = 1'b0;

      check_eq("latency",  64'(lat), 64'(exp_lat));
      check_eq("pslverr",  64'(got_err), 64'(exp_err));
      check_eq("prdata",   64'(got_rd), 64'(exp_rd));
      check_eq("wr_count", 64'(n_wr), 64'((legal && wr) ? 1 : 0));
      check_eq("rd_count", 64'(n_rd), 64'((legal && !wr) ? 1 : 0));
      if (legal && wr && n_wr == 1) begin
         check_eq("wr_cycle", 64'(wr_k), 64'(1));
         check_eq("wr_addr",  64'(wr_addr), 64'(addr));
         check_eq("wr_data",  64'(wr_data), 64'(wdata));
         check_eq("wr_be",    64'(wr_be), 64'(exp_be));
      end
      if (legal && !wr && n_rd == 1) begin
         check_eq("rd_cycle", 64'(rd_k), 64'(1));
         check_eq("rd_addr",  64'(rd_addr), 64'(addr));
      end

      if (legal && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (exp_be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      model_prdata = exp_rd;
   endtask

   // Pulse reg_rd_valid once while idle; the bridge must not respond
   task automatic stray_valid(input string tag);
      @(negedge clk);
      bus.reg_rd_valid = 1'b1; bus.reg_rd_data = 32'hBAD0BAD0;
      @(negedge clk);
      bus.reg_rd_valid = 1'b0;
      check_eq(tag, 64'(bus.pready), 64'(0));
      @(negedge clk);
      check_eq(tag, 64'(bus.pready), 64'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, 64'({bus.pready, bus.pslverr, bus.reg_wr_en, bus.reg_rd_en}), 64'(0));
      check_eq(tag, 64'(bus.prdata), 64'(0));
      check_eq(tag, 64'({bus.reg_wr_addr, bus.reg_rd_addr, bus.reg_wr_be}), 64'(0));
      check_eq(tag, 64'(bus.reg_wr_data), 64'(0));
   endtask

   initial begin
      logic [AW-1:0] a;
      int            d;

      bus.paddr = '0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pwdata = '0;
`ifdef APB_PSTRB_EN
      bus.pstrb = '0;
`endif
      bus.reg_rd_data = '0; bus.reg_rd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         regfile[i] = $urandom; model_mem[i] = regfile[i];
      end
      model_prdata = 32'h0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      rst = 1'b0;

      // Basic write and zero-latency read
      apb_xfer(8'h04, 1'b1, 32'hCAFEF00D, 4'hF, 0);
      regfile[3] = 32'hDEADBEEF; model_mem[3] = 32'hDEADBEEF;
      apb_xfer(8'h0C, 1'b0, 32'h0, 4'h0, 0);

      // Delayed read, withheld read, then a stray valid
      apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, 3);
      apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, 100);
      stray_valid("late_valid_after_timeout");

      // Timeout boundary: valid in the last waiting cycle still wins
      apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, TIMEOUT - 1);
      apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, TIMEOUT);

      // Range and alignment errors
      apb_xfer(8'h10, 1'b1, 32'h55AA55AA, 4'hF, 0);
      apb_xfer(8'h06, 1'b0, 32'h0, 4'h0, 0);
      apb_xfer(8'h0E, 1'b1, 32'h11111111, 4'hF, 0);
      for (int i = 0; i < 4; i++) check_eq("regfile_after_err", 64'(regfile[i]), 64'(model_mem[i]));

      // Byte strobes, including an all-zero strobe
      apb_xfer(8'h08, 1'b1, 32'h12345678, 4'b0101, 0);
      apb_xfer(8'h08, 1'b1, 32'h9ABCDEF0, 4'b0000, 0);
      apb_xfer(8'h08, 1'b0, 32'h0, 4'hF, 1);

      // Master drops psel while the read is pending
      @(negedge clk);
      bus.paddr = 8'h04; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      repeat (3) @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_no_pready", 64'(bus.pready), 64'(0));
      end
      stray_valid("late_valid_after_abort");
      apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, 2);

      // Reset while waiting for read data
      @(negedge clk);
      bus.paddr = 8'h0C; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      @(negedge clk);
      check_eq("strobe_before_reset", 64'(bus.reg_rd_en), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_read_reset");
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_eq("reset_no_pready", 64'(bus.pready), 64'(0));
      model_prdata = 32'h0;
      apb_xfer(8'h00, 1'b1, 32'h0BADF00D, 4'hF, 0);
      apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, 0);

      // Random traffic
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) < 7) a = AW'($urandom_range(0, 3) * 4);
         else                          a = AW'($urandom_range(0, 'h1F));
         if ($urandom_range(0, 7) == 0) d = int'($urandom_range(TIMEOUT, TIMEOUT + 4));
         else                           d = int'($urandom_range(0, TIMEOUT - 1));
         apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), d);
      end

      for (int i = 0; i < 4; i++) check_eq("regfile_final", 64'(regfile[i]), 64'(model_mem[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
